// File: rtl/eth_pkg.sv
// eth_pkg: shared constants, dispatcher state encoding and the byte-wise
// CRC-32 step used by the Ethernet receive dispatcher.
package eth_pkg;

  localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
  localparam logic [7:0]  ETH_SFD         = 8'hD5;
  localparam logic [15:0] ETH_TYPE_ARP    = 16'h0806;
  localparam logic [15:0] ETH_TYPE_IPV4   = 16'h0800;
  localparam logic [47:0] ETH_BCAST_MAC   = 48'hFFFF_FFFF_FFFF;
  localparam logic [31:0] ETH_CRC_RESIDUE = 32'hC704DD7B;
  localparam logic [31:0] ETH_CRC_POLY    = 32'h04C11DB7;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_HEADER   = 3'd2,
    ST_PAYLOAD  = 3'd3,
    ST_DROP     = 3'd4
  } eth_rx_state_t;

  // One byte of the Ethernet CRC, bits consumed LSB first (reflected input).
  // The register is kept MSB-first so the good-frame residue is 0xC704DD7B.
  function automatic logic [31:0] eth_crc32_d8_next(input logic [31:0] crc,
                                                    input logic [7:0]  d);
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      fb = c[31] ^ d[i];
      c  = {c[30:0], 1'b0} ^ (fb ? ETH_CRC_POLY : 32'h0000_0000);
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// eth_crc32_d8: byte-wise CRC-32 register. i_init preloads all ones at the
// start of a frame, i_en folds in one received byte per cycle.
module eth_crc32_d8
  import eth_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_init,
  input  logic        i_en,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc
);

  logic [31:0] r_crc;

  // CRC accumulator: preload on init, update on each enabled byte.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_crc <= 32'hFFFF_FFFF;
    end else if (i_init) begin
      r_crc <= 32'hFFFF_FFFF;
    end else if (i_en) begin
      r_crc <= eth_crc32_d8_next(r_crc, i_data);
    end else begin
      r_crc <= r_crc;
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/eth_rx_dispatch.sv
// eth_rx_dispatch: frames the RGMII receive byte stream, filters on
// destination MAC, and steers ARP / IPv4 payloads (FCS stripped through a
// 5-byte delay line) to two streams. Defining ETH_RX_CRC_CHECK_EN adds an
// FCS check reported on tuser with tlast; otherwise tuser stays 0.
module eth_rx_dispatch
  import eth_pkg::*;
#(
  parameter logic [47:0] LOCAL_MAC = 48'h00_0A_35_01_FE_C0
) (
  input  logic        rx_mac_aclk,
  input  logic        rx_mac_reset,
  input  logic [7:0]  rx_axis_rgmii_tdata,
  input  logic        rx_axis_rgmii_tvalid,
  output logic [7:0]  m_arp_tdata,
  output logic        m_arp_tvalid,
  output logic        m_arp_tlast,
  output logic        m_arp_tuser,
  output logic [7:0]  m_ip_tdata,
  output logic        m_ip_tvalid,
  output logic        m_ip_tlast,
  output logic        m_ip_tuser,
  output logic [47:0] rx_src_mac,
  output logic [15:0] rx_frame_cnt,
  output logic [15:0] rx_drop_cnt
);

  eth_rx_state_t r_state;
  logic [3:0]    r_hdr_cnt;
  logic          r_ucast_ok;
  logic          r_bcast_ok;
  logic [47:0]   r_src_shadow;
  logic [7:0]    r_type_hi;
  logic          r_to_ip;
  logic [7:0]    r_dl [5];
  logic [2:0]    r_dl_cnt;
  logic          r_src_loaded;
  logic          r_prev_tvalid;

  logic [7:0]    w_local_byte;
  logic [15:0]   w_type;
  logic          w_accept;
  logic          w_emit;
  logic          w_emit_last;
  logic          w_drop_inc;
  logic          w_crc_bad;

  assign w_type   = {r_type_hi, rx_axis_rgmii_tdata};
  assign w_accept = (r_ucast_ok || r_bcast_ok) &&
                    ((w_type == ETH_TYPE_ARP) || (w_type == ETH_TYPE_IPV4));

`ifdef ETH_RX_CRC_CHECK_EN
  logic [31:0] w_crc;
  logic        w_crc_init;
  logic        w_crc_en;

  assign w_crc_init = rx_axis_rgmii_tvalid && (r_state == ST_PREAMBLE) &&
                      (rx_axis_rgmii_tdata == ETH_SFD);
  assign w_crc_en   = rx_axis_rgmii_tvalid &&
                      ((r_state == ST_HEADER) || (r_state == ST_PAYLOAD));

  eth_crc32_d8 u_crc (
    .i_clk  (rx_mac_aclk),
    .i_rst  (rx_mac_reset),
    .i_init (w_crc_init),
    .i_en   (w_crc_en),
    .i_data (rx_axis_rgmii_tdata),
    .o_crc  (w_crc)
  );

  // At end of frame every byte through the FCS has been folded in.
  assign w_crc_bad = (w_crc != ETH_CRC_RESIDUE);
`else
  assign w_crc_bad = 1'b0;
`endif

  // Destination MAC byte expected at the current header position.
  always_comb begin
    w_local_byte = 8'h00;
    case (r_hdr_cnt)
      4'd0:    w_local_byte = LOCAL_MAC[47:40];
      4'd1:    w_local_byte = LOCAL_MAC[39:32];
      4'd2:    w_local_byte = LOCAL_MAC[31:24];
      4'd3:    w_local_byte = LOCAL_MAC[23:16];
      4'd4:    w_local_byte = LOCAL_MAC[15:8];
      4'd5:    w_local_byte = LOCAL_MAC[7:0];
      default: w_local_byte = 8'h00;
    endcase
  end

  // Per-cycle decisions: emit a delay-line byte, close a frame, count a drop.
  // A non-preamble byte in IDLE only counts when it really starts a frame,
  // so the tail of a frame cut by reset is ignored.
  always_comb begin
    w_emit      = 1'b0;
    w_emit_last = 1'b0;
    w_drop_inc  = 1'b0;
    if (rx_axis_rgmii_tvalid) begin
      case (r_state)
        ST_IDLE:     w_drop_inc = (rx_axis_rgmii_tdata != ETH_PREAMBLE) && !r_prev_tvalid;
        ST_PREAMBLE: w_drop_inc = (rx_axis_rgmii_tdata != ETH_PREAMBLE) &&
                                  (rx_axis_rgmii_tdata != ETH_SFD);
        ST_HEADER:   w_drop_inc = (r_hdr_cnt == 4'd13) && !w_accept;
        ST_PAYLOAD:  w_emit     = (r_dl_cnt == 3'd5);
        default:     w_drop_inc = 1'b0;
      endcase
    end else begin
      case (r_state)
        ST_PREAMBLE: w_drop_inc = 1'b1;
        ST_HEADER:   w_drop_inc = 1'b1;
        ST_PAYLOAD: begin
          if (r_dl_cnt == 3'd5) begin
            w_emit      = 1'b1;
            w_emit_last = 1'b1;
          end else begin
            w_drop_inc  = 1'b1;
          end
        end
        default:     w_drop_inc = 1'b0;
      endcase
    end
  end

  // Frame FSM: preamble/SFD hunt, header parse, payload delay line.
  always_ff @(posedge rx_mac_aclk) begin
    if (rx_mac_reset) begin
      r_state       <= ST_IDLE;
      r_hdr_cnt     <= 4'd0;
      r_ucast_ok    <= 1'b0;
      r_bcast_ok    <= 1'b0;
      r_src_shadow  <= 48'h0;
      r_type_hi     <= 8'h00;
      r_to_ip       <= 1'b0;
      r_dl_cnt      <= 3'd0;
      r_src_loaded  <= 1'b0;
      r_prev_tvalid <= 1'b1;
      for (int i = 0; i < 5; i++) r_dl[i] <= 8'h00;
    end else begin
      r_prev_tvalid <= rx_axis_rgmii_tvalid;
      if (!rx_axis_rgmii_tvalid) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state <= (rx_axis_rgmii_tdata == ETH_PREAMBLE) ? ST_PREAMBLE : ST_DROP;
          end
          ST_PREAMBLE: begin
            if (rx_axis_rgmii_tdata == ETH_SFD) begin
              r_state      <= ST_HEADER;
              r_hdr_cnt    <= 4'd0;
              r_ucast_ok   <= 1'b1;
              r_bcast_ok   <= 1'b1;
              r_dl_cnt     <= 3'd0;
              r_src_loaded <= 1'b0;
            end else if (rx_axis_rgmii_tdata != ETH_PREAMBLE) begin
              r_state <= ST_DROP;
            end
          end
          ST_HEADER: begin
            r_hdr_cnt <= r_hdr_cnt + 4'd1;
            if (r_hdr_cnt < 4'd6) begin
              r_ucast_ok <= r_ucast_ok && (rx_axis_rgmii_tdata == w_local_byte);
              r_bcast_ok <= r_bcast_ok && (rx_axis_rgmii_tdata == ETH_BCAST_MAC[7:0]);
            end else if (r_hdr_cnt < 4'd12) begin
              r_src_shadow <= {r_src_shadow[39:0], rx_axis_rgmii_tdata};
            end else if (r_hdr_cnt == 4'd12) begin
              r_type_hi <= rx_axis_rgmii_tdata;
            end else begin
              r_to_ip <= (w_type == ETH_TYPE_IPV4);
              r_state <= w_accept ? ST_PAYLOAD : ST_DROP;
            end
          end
          ST_PAYLOAD: begin
            r_dl[0] <= rx_axis_rgmii_tdata;
            for (int i = 1; i < 5; i++) r_dl[i] <= r_dl[i-1];
            if (r_dl_cnt != 3'd5) r_dl_cnt <= r_dl_cnt + 3'd1;
            if (w_emit) r_src_loaded <= 1'b1;
          end
          ST_DROP: r_state <= ST_DROP;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // Registered output streams, source MAC and frame/drop counters.
  always_ff @(posedge rx_mac_aclk) begin
    if (rx_mac_reset) begin
      m_arp_tdata  <= 8'h00;
      m_arp_tvalid <= 1'b0;
      m_arp_tlast  <= 1'b0;
      m_arp_tuser  <= 1'b0;
      m_ip_tdata   <= 8'h00;
      m_ip_tvalid  <= 1'b0;
      m_ip_tlast   <= 1'b0;
      m_ip_tuser   <= 1'b0;
      rx_src_mac   <= 48'h0;
      rx_frame_cnt <= 16'd0;
      rx_drop_cnt  <= 16'd0;
    end else begin
      m_arp_tvalid <= w_emit && !r_to_ip;
      m_arp_tlast  <= w_emit_last && !r_to_ip;
      m_arp_tuser  <= w_emit_last && !r_to_ip && w_crc_bad;
      m_ip_tvalid  <= w_emit && r_to_ip;
      m_ip_tlast   <= w_emit_last && r_to_ip;
      m_ip_tuser   <= w_emit_last && r_to_ip && w_crc_bad;
      if (w_emit && r_to_ip) m_ip_tdata <= r_dl[4];
      if (w_emit && !r_to_ip) m_arp_tdata <= r_dl[4];
      if (w_emit && !r_src_loaded) rx_src_mac <= r_src_shadow;
      if (w_emit_last) rx_frame_cnt <= rx_frame_cnt + 16'd1;
      if (w_drop_inc) rx_drop_cnt <= rx_drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_eth_rx_dispatch.sv
// tb_eth_rx_dispatch: directed and randomized frames checked against a
// frame-level reference model (whole-frame parsing, queues of expected beats).
module tb_eth_rx_dispatch;

  localparam logic [47:0] LOCAL_MAC = 48'h000A3501FEC0;
  localparam logic [47:0] BCAST     = 48'hFFFFFFFFFFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_tdata;
  logic        rx_tvalid;
  logic [7:0]  m_arp_tdata, m_ip_tdata;
  logic        m_arp_tvalid, m_arp_tlast, m_arp_tuser;
  logic        m_ip_tvalid, m_ip_tlast, m_ip_tuser;
  logic [47:0] rx_src_mac;
  logic [15:0] rx_frame_cnt, rx_drop_cnt;

  eth_rx_dispatch #(.LOCAL_MAC(LOCAL_MAC)) dut (
    .rx_mac_aclk          (clk),
    .rx_mac_reset         (rst),
    .rx_axis_rgmii_tdata  (rx_tdata),
    .rx_axis_rgmii_tvalid (rx_tvalid),
    .m_arp_tdata          (m_arp_tdata),
    .m_arp_tvalid         (m_arp_tvalid),
    .m_arp_tlast          (m_arp_tlast),
    .m_arp_tuser          (m_arp_tuser),
    .m_ip_tdata           (m_ip_tdata),
    .m_ip_tvalid          (m_ip_tvalid),
    .m_ip_tlast           (m_ip_tlast),
    .m_ip_tuser           (m_ip_tuser),
    .rx_src_mac           (rx_src_mac),
    .rx_frame_cnt         (rx_frame_cnt),
    .rx_drop_cnt          (rx_drop_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  wire_q[$];
  logic [9:0]  arp_q[$];
  logic [9:0]  ip_q[$];
  int          drive_cyc[$];
  int          exp_frames, exp_drops, first_pay_idx, first_out_cyc;
  logic [47:0] exp_src;
  logic [9:0]  e_arp, e_ip;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc32_ref(input logic [7:0] b[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < b.size(); i++) begin
      c = c ^ {24'h0, b[i]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  // mode: 0 random bytes, 1 incrementing from 0x01, 2 random avoiding 0x55
  task automatic build_frame(input logic [47:0] dst, input logic [47:0] src,
                             input logic [15:0] typ, input int pay_len, input int mode,
                             input bit fcs_en, input bit bad_fcs);
    logic [7:0]  body[$];
    logic [31:0] f;
    body = {};
    for (int i = 0; i < 6; i++) body.push_back(dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) body.push_back(src[47-8*i -: 8]);
    body.push_back(typ[15:8]);
    body.push_back(typ[7:0]);
    for (int k = 0; k < pay_len; k++) begin
      if (mode == 1) body.push_back(8'(k + 1));
      else if (mode == 2) body.push_back(8'($urandom_range(0, 84)));
      else body.push_back(8'($urandom_range(0, 255)));
    end
    wire_q.delete();
    repeat (7) wire_q.push_back(8'h55);
    wire_q.push_back(8'hD5);
    foreach (body[i]) wire_q.push_back(body[i]);
    if (fcs_en) begin
      f = crc32_ref(body);
      if (bad_fcs) f = f ^ 32'h0000_0010;
      wire_q.push_back(f[7:0]);
      wire_q.push_back(f[15:8]);
      wire_q.push_back(f[23:16]);
      wire_q.push_back(f[31:24]);
    end
  endtask

  // Frame-level model: parse the whole wire frame and queue the expected beats.
  task automatic model_frame();
    int          i, n, base, sz;
    logic [47:0] dst, src;
    logic [15:0] typ;
    logic [7:0]  data_b[$];
    logic [31:0] fcs_rx;
    bit          bad, last;
    sz = wire_q.size();
    i = 0;
    if (sz == 0 || wire_q[0] != 8'h55) begin exp_drops++; return; end
    while (i < sz && wire_q[i] == 8'h55) i++;
    if (i >= sz || wire_q[i] != 8'hD5) begin exp_drops++; return; end
    base = i + 1;
    n = sz - base;
    if (n < 14) begin exp_drops++; return; end
    dst = 48'h0;
    src = 48'h0;
    for (int k = 0; k < 6; k++) begin
      dst = {dst[39:0], wire_q[base+k]};
      src = {src[39:0], wire_q[base+6+k]};
    end
    typ = {wire_q[base+12], wire_q[base+13]};
    if (!((dst == LOCAL_MAC) || (dst == BCAST)) ||
        !((typ == 16'h0806) || (typ == 16'h0800)) || (n - 14 < 5)) begin
      exp_drops++;
      return;
    end
    data_b = {};
    for (int k = 0; k < n - 4; k++) data_b.push_back(wire_q[base+k]);
    fcs_rx = {wire_q[sz-1], wire_q[sz-2], wire_q[sz-3], wire_q[sz-4]};
    bad = (crc32_ref(data_b) != fcs_rx);
`ifndef ETH_RX_CRC_CHECK_EN
    bad = 1'b0;
`endif
    for (int k = base + 14; k <= sz - 5; k++) begin
      last = (k == sz - 5);
      if (typ == 16'h0800) ip_q.push_back({bad && last, last, wire_q[k]});
      else arp_q.push_back({bad && last, last, wire_q[k]});
    end
    exp_frames++;
    exp_src = src;
    first_pay_idx = base + 14;
  endtask

  task automatic drive_frame(input int rst_at, input int gap);
    drive_cyc.delete();
    for (int i = 0; i < wire_q.size(); i++) begin
      rx_tdata  = wire_q[i];
      rx_tvalid = 1'b1;
      rst       = (i == rst_at);
      drive_cyc.push_back(cyc);
      @(posedge clk); #1;
      if (i == rst_at) begin
        rst = 1'b0;
        arp_q.delete();
        ip_q.delete();
        exp_frames = 0;
        exp_drops  = 0;
        exp_src    = 48'h0;
        chk("mid_rst_arp_tvalid", 64'(m_arp_tvalid), 64'd0);
        chk("mid_rst_arp_tlast",  64'(m_arp_tlast),  64'd0);
        chk("mid_rst_arp_tdata",  64'(m_arp_tdata),  64'd0);
        chk("mid_rst_ip_tvalid",  64'(m_ip_tvalid),  64'd0);
        chk("mid_rst_frame_cnt",  64'(rx_frame_cnt), 64'd0);
        chk("mid_rst_drop_cnt",   64'(rx_drop_cnt),  64'd0);
        chk("mid_rst_src_mac",    64'(rx_src_mac),   64'd0);
      end
    end
    rx_tvalid = 1'b0;
    rx_tdata  = 8'h00;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic check_after(input string tag);
    repeat (2) begin @(posedge clk); #1; end
    chk({tag, "_arp_pending"}, 64'(arp_q.size()), 64'd0);
    chk({tag, "_ip_pending"},  64'(ip_q.size()),  64'd0);
    chk({tag, "_frame_cnt"},   64'(rx_frame_cnt), 64'(exp_frames[15:0]));
    chk({tag, "_drop_cnt"},    64'(rx_drop_cnt),  64'(exp_drops[15:0]));
    chk({tag, "_src_mac"},     64'(rx_src_mac),   64'(exp_src));
  endtask

  // Output monitor: every beat must match the head of its port's queue.
  always @(negedge clk) begin
    if (m_arp_tvalid || m_ip_tvalid)
      chk("exclusive_tvalid", 64'(m_arp_tvalid & m_ip_tvalid), 64'd0);
    if (m_arp_tvalid) begin
      if (first_out_cyc < 0) first_out_cyc = cyc;
      if (arp_q.size() == 0) begin
        n_vec++; n_err++;
        $error("FAIL arp_unexpected: observed beat 0x%0h expected no beat", m_arp_tdata);
      end else begin
        e_arp = arp_q.pop_front();
        chk("arp_data", 64'(m_arp_tdata), 64'(e_arp[7:0]));
        chk("arp_last", 64'(m_arp_tlast), 64'(e_arp[8]));
        if (e_arp[8]) chk("arp_user", 64'(m_arp_tuser), 64'(e_arp[9]));
      end
    end else if (m_arp_tlast) begin
      n_vec++; n_err++;
      $error("FAIL arp_idle_tlast: observed tlast 1 expected 0");
    end
    if (m_ip_tvalid) begin
      if (first_out_cyc < 0) first_out_cyc = cyc;
      if (ip_q.size() == 0) begin
        n_vec++; n_err++;
        $error("FAIL ip_unexpected: observed beat 0x%0h expected no beat", m_ip_tdata);
      end else begin
        e_ip = ip_q.pop_front();
        chk("ip_data", 64'(m_ip_tdata), 64'(e_ip[7:0]));
        chk("ip_last", 64'(m_ip_tlast), 64'(e_ip[8]));
        if (e_ip[8]) chk("ip_user", 64'(m_ip_tuser), 64'(e_ip[9]));
      end
    end else if (m_ip_tlast) begin
      n_vec++; n_err++;
      $error("FAIL ip_idle_tlast: observed tlast 1 expected 0");
    end
  end

  initial begin
    int          d0;
    logic [63:0] rnd;
    logic [47:0] dst;
    logic [15:0] typ;
    rst = 1'b1; rx_tdata = 8'h00; rx_tvalid = 1'b0;
    exp_frames = 0; exp_drops = 0; exp_src = 48'h0; first_out_cyc = 0; first_pay_idx = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_arp_tvalid", 64'(m_arp_tvalid), 64'd0);
    chk("rst_arp_tlast",  64'(m_arp_tlast),  64'd0);
    chk("rst_arp_tuser",  64'(m_arp_tuser),  64'd0);
    chk("rst_arp_tdata",  64'(m_arp_tdata),  64'd0);
    chk("rst_ip_tvalid",  64'(m_ip_tvalid),  64'd0);
    chk("rst_ip_tdata",   64'(m_ip_tdata),   64'd0);
    chk("rst_src_mac",    64'(rx_src_mac),   64'd0);
    chk("rst_frame_cnt",  64'(rx_frame_cnt), 64'd0);
    chk("rst_drop_cnt",   64'(rx_drop_cnt),  64'd0);
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // ARP broadcast, payload 0x01..0x1C
    build_frame(BCAST, 48'h001122334455, 16'h0806, 28, 1, 1'b1, 1'b0);
    model_frame();
    drive_frame(-1, 1);
    check_after("arp_bcast");
    chk("arp_bcast_src_const", 64'(rx_src_mac), 64'h001122334455);
    chk("arp_bcast_frames_const", 64'(rx_frame_cnt), 64'd1);

    // IPv4 unicast, 46 random bytes, first-byte latency
    rnd = {$urandom(), $urandom()};
    build_frame(LOCAL_MAC, rnd[47:0], 16'h0800, 46, 0, 1'b1, 1'b0);
    model_frame();
    first_out_cyc = -1;
    drive_frame(-1, 2);
    check_after("ip_ucast");
    chk("ip_first_latency", 64'(first_out_cyc - drive_cyc[first_pay_idx]), 64'd6);

    // Filtering: foreign unicast, then IPv6 EtherType
    d0 = exp_drops;
    build_frame(48'h020000000001, 48'h0A0B0C0D0E0F, 16'h0800, 20, 0, 1'b1, 1'b0);
    model_frame(); drive_frame(-1, 2); check_after("filter_dst");
    build_frame(LOCAL_MAC, 48'h0A0B0C0D0E0F, 16'h86DD, 20, 0, 1'b1, 1'b0);
    model_frame(); drive_frame(-1, 2); check_after("filter_type");
    chk("filter_drops", 64'(rx_drop_cnt), 64'(d0 + 2));

    // Runt after 8 header bytes, then a frame starting with 0x5D
    d0 = exp_drops;
    build_frame(LOCAL_MAC, 48'h111111111111, 16'h0800, 30, 0, 1'b1, 1'b0);
    while (wire_q.size() > 16) void'(wire_q.pop_back());
    model_frame(); drive_frame(-1, 2); check_after("runt");
    build_frame(LOCAL_MAC, 48'h222222222222, 16'h0800, 30, 0, 1'b1, 1'b0);
    wire_q[0] = 8'h5D;
    model_frame(); drive_frame(-1, 2); check_after("bad_pre");
    chk("runt_badpre_drops", 64'(rx_drop_cnt), 64'(d0 + 2));
    build_frame(LOCAL_MAC, 48'h333333333333, 16'h0806, 28, 0, 1'b1, 1'b0);
    model_frame(); drive_frame(-1, 2); check_after("after_runt");

    // Payload-length boundaries
    build_frame(BCAST, 48'h444444444444, 16'h0806, 1, 0, 1'b1, 1'b0);
    model_frame(); drive_frame(-1, 2); check_after("pay_one");
    build_frame(BCAST, 48'h555555555555, 16'h0806, 0, 0, 1'b1, 1'b0);
    model_frame(); drive_frame(-1, 2); check_after("pay_zero");
    build_frame(BCAST, 48'h666666666666, 16'h0800, 3, 0, 1'b0, 1'b0);
    model_frame(); drive_frame(-1, 2); check_after("pay_short");

    // Corrupted FCS (flagged only when the CRC check is built in)
    build_frame(LOCAL_MAC, 48'h777777777777, 16'h0800, 40, 0, 1'b1, 1'b1);
    model_frame(); drive_frame(-1, 2); check_after("bad_fcs");

    // Back-to-back ARP frames with one idle cycle
    build_frame(BCAST, 48'h888888888888, 16'h0806, 28, 0, 1'b1, 1'b0);
    model_frame(); drive_frame(-1, 1);
    build_frame(LOCAL_MAC, 48'h999999999999, 16'h0806, 28, 0, 1'b1, 1'b0);
    model_frame(); drive_frame(-1, 1);
    check_after("b2b");

    // Randomized mix of addresses, types and lengths
    for (int f = 0; f < 10; f++) begin
      rnd = {$urandom(), $urandom()};
      case ($urandom_range(0, 2))
        0: dst = LOCAL_MAC;
        1: dst = BCAST;
        default: dst = {8'h02, rnd[39:0]};
      endcase
      case ($urandom_range(0, 2))
        0: typ = 16'h0806;
        1: typ = 16'h0800;
        default: typ = 16'h86DD;
      endcase
      build_frame(dst, {rnd[63:48], rnd[31:0]}, typ, $urandom_range(0, 50), 0,
                  1'b1, ($urandom_range(0, 3) == 0));
      model_frame();
      drive_frame(-1, $urandom_range(1, 3));
    end
    check_after("random");

    // Reset in the middle of an ARP payload
    build_frame(BCAST, 48'hABCDEF012345, 16'h0806, 30, 2, 1'b1, 1'b0);
    model_frame();
    drive_frame(8 + 14 + 12, 2);
    check_after("mid_rst");
    build_frame(LOCAL_MAC, 48'h0123456789AB, 16'h0800, 24, 0, 1'b1, 1'b0);
    model_frame(); drive_frame(-1, 2); check_after("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
